pulse_seq_ctrl: RTL and testbench

//   Table-driven pulse sequencer for the NV controller: steps through up to NUM_STEPS programmed
//   (duration, channel pattern) entries on a run-time programmable prescaled time base.

---
 rtl/pulse_seq_ctrl.sv | 181 ++++++++++++++++++
 tb/tb_pulse_seq_ctrl.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pulse_seq_ctrl.sv
// pulse_seq_ctrl: table-driven pulse sequencer.
// Steps through up to NumSteps programmed (duration, channel pattern, last) entries on a
// run-time programmable prescaled time base and repeats the pass repeat_n_i times (0 = forever).
// Ports:
//   clk_i, rst_i        clock, synchronous active-high reset
//   cfg_we_i/addr/dur/  table write port, honoured only while idle
//   pat/last_i
//   prescale_i          tick period = prescale_i+1 cycles, sampled on start
//   repeat_n_i          number of passes (0 = infinite), sampled on start
//   start_i, stop_i     1-cycle start / abort requests
//   busy_o, done_o      running flag, 1-cycle completion pulse
//   ch_out_o            registered channel outputs (laser, MW, APD gate, trigger)
//   step_idx_o          active step index
//   tick_o              prescaler wrap strobe
module pulse_seq_ctrl #(
  parameter int unsigned NumSteps = 16,
  parameter int unsigned AddrW    = 4,
  parameter int unsigned DurW     = 16,
  parameter int unsigned ChW      = 4,
  parameter int unsigned PreW     = 11,
  parameter int unsigned RepW     = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             cfg_we_i,
  input  logic [AddrW-1:0] cfg_addr_i,
  input  logic [DurW-1:0]  cfg_dur_i,
  input  logic [ChW-1:0]   cfg_pat_i,
  input  logic             cfg_last_i,
  input  logic [PreW-1:0]  prescale_i,
  input  logic [RepW-1:0]  repeat_n_i,
  input  logic             start_i,
  input  logic             stop_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [ChW-1:0]   ch_out_o,
  output logic [AddrW-1:0] step_idx_o,
  output logic             tick_o
);

  typedef enum logic [0:0] {StIdle, StRun} state_e;

  state_e           state_q, state_d;
  logic [PreW-1:0]  prescale_q, prescale_d;
  logic [PreW-1:0]  pre_cnt_q, pre_cnt_d;
  logic [RepW-1:0]  repeat_q, repeat_d;
  logic [RepW-1:0]  pass_q, pass_d;
  logic [DurW-1:0]  remain_q, remain_d;
  logic [AddrW-1:0] step_q, step_d;
  logic [ChW-1:0]   ch_q, ch_d;
  logic             done_q, done_d;
  logic             tick_q, tick_d;

  logic [DurW-1:0]  dur_q  [NumSteps];
  logic [ChW-1:0]   pat_q  [NumSteps];
  logic             last_q [NumSteps];

  logic [AddrW-1:0] next_step;
  logic             wrap;
  logic             pass_end;

  // A programmed duration of zero behaves as one tick.
  function automatic logic [DurW-1:0] eff_dur(input logic [DurW-1:0] d);
    return (d == '0) ? DurW'(1) : d;
  endfunction

  // Step table; writes are locked out while a sequence runs.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < int'(NumSteps); i++) begin
        dur_q[i]  <= '0;
        pat_q[i]  <= '0;
        last_q[i] <= 1'b0;
      end
    end else if (cfg_we_i && (state_q == StIdle)) begin
      dur_q[cfg_addr_i]  <= cfg_dur_i;
      pat_q[cfg_addr_i]  <= cfg_pat_i;
      last_q[cfg_addr_i] <= cfg_last_i;
    end
  end

  assign next_step = step_q + AddrW'(1);
  assign wrap      = (pre_cnt_q == prescale_q);
  assign pass_end  = last_q[step_q] || (step_q == AddrW'(NumSteps - 1));

  always_comb begin
    state_d    = state_q;
    prescale_d = prescale_q;
    pre_cnt_d  = pre_cnt_q;
    repeat_d   = repeat_q;
    pass_d     = pass_q;
    remain_d   = remain_q;
    step_d     = step_q;
    ch_d       = ch_q;
    done_d     = 1'b0;
    tick_d     = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start_i && !stop_i) begin
          state_d    = StRun;
          prescale_d = prescale_i;
          repeat_d   = repeat_n_i;
          pass_d     = '0;
          pre_cnt_d  = '0;
          step_d     = '0;
          remain_d   = eff_dur(dur_q[0]);
          ch_d       = pat_q[0];
        end
      end
      StRun: begin
        if (stop_i) begin
          state_d   = StIdle;
          ch_d      = '0;
          step_d    = '0;
          pre_cnt_d = '0;
        end else begin
          pre_cnt_d = wrap ? '0 : pre_cnt_q + PreW'(1);
          if (wrap) begin
            if (remain_q > DurW'(1)) begin
              remain_d = remain_q - DurW'(1);
            end else if (!pass_end) begin
              step_d   = next_step;
              ch_d     = pat_q[next_step];
              remain_d = eff_dur(dur_q[next_step]);
            end else if ((repeat_q == '0) || (pass_q + RepW'(1) != repeat_q)) begin
              // Start another pass; the counter is frozen in infinite mode.
              if (repeat_q != '0) pass_d = pass_q + RepW'(1);
              step_d   = '0;
              ch_d     = pat_q[0];
              remain_d = eff_dur(dur_q[0]);
            end else begin
              state_d   = StIdle;
              ch_d      = '0;
              step_d    = '0;
              pre_cnt_d = '0;
              done_d    = 1'b1;
            end
          end
        end
      end
      default: state_d = StIdle;
    endcase

    // tick_o is high during the cycle whose closing edge wraps the prescaler.
    tick_d = (state_d == StRun) && (pre_cnt_d == prescale_d);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= StIdle;
      prescale_q <= '0;
      pre_cnt_q  <= '0;
      repeat_q   <= '0;
      pass_q     <= '0;
      remain_q   <= '0;
      step_q     <= '0;
      ch_q       <= '0;
      done_q     <= 1'b0;
      tick_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      prescale_q <= prescale_d;
      pre_cnt_q  <= pre_cnt_d;
      repeat_q   <= repeat_d;
      pass_q     <= pass_d;
      remain_q   <= remain_d;
      step_q     <= step_d;
      ch_q       <= ch_d;
      done_q     <= done_d;
      tick_q     <= tick_d;
    end
  end

  assign busy_o     = (state_q == StRun);
  assign done_o     = done_q;
  assign ch_out_o   = ch_q;
  assign step_idx_o = step_q;
  assign tick_o     = tick_q;

endmodule

// File: tb/tb_pulse_seq_ctrl.sv
// Self-checking bench for pulse_seq_ctrl: a behavioural model expands each programmed run into
// a per-cycle expected trace queue, which is popped and compared against the DUT every cycle.
module tb_pulse_seq_ctrl;

  typedef struct packed {
    logic       busy;
    logic       done;
    logic       tick;
    logic [3:0] ch;
    logic [3:0] idx;
  } obs_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cfg_we = 1'b0;
  logic [3:0]  cfg_addr = '0;
  logic [15:0] cfg_dur = '0;
  logic [3:0]  cfg_pat = '0;
  logic        cfg_last = 1'b0;
  logic [10:0] prescale = '0;
  logic [15:0] repeat_n = '0;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic        busy, done, tick;
  logic [3:0]  ch_out, step_idx;

  int   total = 0;
  int   bad = 0;
  obs_t sb_q[$];

  int         tb_dur [16];
  logic [3:0] tb_pat [16];
  bit         tb_last[16];

  pulse_seq_ctrl dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .cfg_we_i   (cfg_we),
    .cfg_addr_i (cfg_addr),
    .cfg_dur_i  (cfg_dur),
    .cfg_pat_i  (cfg_pat),
    .cfg_last_i (cfg_last),
    .prescale_i (prescale),
    .repeat_n_i (repeat_n),
    .start_i    (start),
    .stop_i     (stop),
    .busy_o     (busy),
    .done_o     (done),
    .ch_out_o   (ch_out),
    .step_idx_o (step_idx),
    .tick_o     (tick)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic clear_model();
    for (int i = 0; i < 16; i++) begin
      tb_dur[i]  = 0;
      tb_pat[i]  = '0;
      tb_last[i] = 1'b0;
    end
  endtask

  task automatic cfg_write(input int a, input int d, input logic [3:0] p, input bit l);
    @(negedge clk);
    cfg_we = 1'b1; cfg_addr = 4'(a); cfg_dur = 16'(d); cfg_pat = p; cfg_last = l;
    tb_dur[a] = d; tb_pat[a] = p; tb_last[a] = l;
    @(negedge clk);
    cfg_we = 1'b0;
  endtask

  task automatic do_start(input int p, input int rep);
    @(negedge clk);
    prescale = 11'(p); repeat_n = 16'(rep); start = 1'b1;
  endtask

  task automatic push_idle(input int k);
    obs_t e;
    e = '0;
    for (int i = 0; i < k; i++) sb_q.push_back(e);
  endtask

  // Expected trace of a run: each step holds its pattern for max(dur,1)*(p+1) cycles.
  task automatic push_seq(input int p, input int rep, input int maxc, output int n);
    obs_t e;
    int   pass, d;
    bit   fin;
    pass = 0; fin = 1'b0; n = 0;
    while (!fin && n < maxc) begin
      for (int s = 0; s < 16; s++) begin
        d = (tb_dur[s] == 0) ? 1 : tb_dur[s];
        for (int c = 0; c < d * (p + 1); c++) begin
          if (n < maxc) begin
            e.busy = 1'b1; e.done = 1'b0; e.tick = ((c % (p + 1)) == p);
            e.ch = tb_pat[s]; e.idx = 4'(s);
            sb_q.push_back(e);
            n++;
          end
        end
        if (n >= maxc) fin = 1'b1;
        if (fin || tb_last[s]) break;
      end
      if (!fin) begin
        pass++;
        if (rep != 0 && pass == rep) begin
          e = '0; e.done = 1'b1;
          sb_q.push_back(e);
          n++;
          fin = 1'b1;
        end
      end
    end
  endtask

  // Runs n cycles, popping one expected entry per cycle; *_at pulse the named input at that cycle.
  task automatic run_check(input string name, input int n, input int stop_at, input int start_at,
                           input int we_at, input int rst_at);
    obs_t got, exp_v;
    for (int i = 1; i <= n; i++) begin
      @(negedge clk);
      start = (i == start_at);
      stop  = (i == stop_at);
      rst   = (i == rst_at);
      if (i == we_at) begin
        cfg_we = 1'b1; cfg_addr = 4'd0; cfg_dur = 16'd5; cfg_pat = 4'hf; cfg_last = 1'b1;
      end else begin
        cfg_we = 1'b0;
      end
      got = {busy, done, tick, ch_out, step_idx};
      total++;
      if (sb_q.size() == 0) begin
        bad++;
        $display("FAIL %s cycle %0d: scoreboard empty, observed %h", name, i, got);
      end else begin
        exp_v = sb_q.pop_front();
        if (got !== exp_v) begin
          bad++;
          $display("FAIL %s cycle %0d: got busy=%b done=%b tick=%b ch=%b idx=%0d, want busy=%b done=%b tick=%b ch=%b idx=%0d",
                   name, i, got.busy, got.done, got.tick, got.ch, got.idx,
                   exp_v.busy, exp_v.done, exp_v.tick, exp_v.ch, exp_v.idx);
        end
      end
    end
    total++;
    if (sb_q.size() != 0) begin
      bad++;
      $display("FAIL %s leftover: %0d expected entries unchecked, want 0", name, sb_q.size());
      sb_q.delete();
    end
  endtask

  task automatic test_reset();
    obs_t got;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    got = {busy, done, tick, ch_out, step_idx};
    total++;
    if (got !== obs_t'(0)) begin
      bad++;
      $display("FAIL reset: got %h, want 0", got);
    end
    rst = 1'b0;
    clear_model();
  endtask

  task automatic test_single();
    int n;
    cfg_write(0, 3, 4'b0001, 1'b1);
    do_start(0, 1);
    push_seq(0, 1, 1000, n);
    push_idle(2);
    run_check("single", n + 2, 0, 0, 0, 0);
  endtask

  task automatic test_multi_pass();
    int n;
    cfg_write(0, 2, 4'b0001, 1'b0);
    cfg_write(1, 1, 4'b0010, 1'b0);
    cfg_write(2, 3, 4'b0100, 1'b1);
    do_start(4, 2);
    push_seq(4, 2, 1000, n);
    push_idle(2);
    // A start pulse mid-run must be ignored.
    run_check("multi_pass", n + 2, 0, 20, 0, 0);
  endtask

  task automatic test_stop_restart();
    int n;
    cfg_write(0, 2, 4'b0011, 1'b0);
    cfg_write(1, 1, 4'b0100, 1'b1);
    do_start(2, 0);
    push_seq(2, 0, 37, n);
    push_idle(3);
    run_check("stop", 40, 37, 0, 0, 0);
    do_start(2, 1);
    push_seq(2, 1, 1000, n);
    push_idle(2);
    run_check("restart", n + 2, 0, 0, 0, 0);
  endtask

  task automatic test_cfg_locked();
    int n;
    cfg_write(0, 0, 4'b1000, 1'b0);
    cfg_write(1, 2, 4'b0110, 1'b1);
    do_start(1, 2);
    push_seq(1, 2, 1000, n);
    push_idle(2);
    run_check("cfg_in_run", n + 2, 0, 0, 3, 0);
    do_start(1, 1);
    push_seq(1, 1, 1000, n);
    push_idle(2);
    run_check("cfg_unchanged", n + 2, 0, 0, 0, 0);
  endtask

  task automatic test_full_table();
    int n;
    for (int i = 0; i < 16; i++) cfg_write(i, 1, 4'(i), 1'b0);
    do_start(0, 1);
    push_seq(0, 1, 1000, n);
    push_idle(2);
    run_check("full_table", n + 2, 0, 0, 0, 0);
  endtask

  task automatic test_rst_mid_run();
    int n;
    cfg_write(0, 4, 4'b0101, 1'b1);
    do_start(1, 1);
    push_seq(1, 1, 3, n);
    clear_model();
    push_idle(3);
    run_check("rst_mid", 6, 0, 0, 0, 3);
    // Cleared table: 16 one-tick steps with pattern 0, then done.
    do_start(0, 1);
    push_seq(0, 1, 1000, n);
    push_idle(2);
    run_check("cleared_table", n + 2, 0, 0, 0, 0);
  endtask

  initial begin
    test_reset();
    test_single();
    test_multi_pass();
    test_stop_restart();
    test_cfg_locked();
    test_full_table();
    test_rst_mid_run();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
